// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and helpers for the load/store memory stage.
//   mem_op_e    - request operation (LOAD/STORE)
//   mem_size_e  - access size encoding (BYTE/WORD/DWORD/ILLEGAL)
//   mem_state_e - control FSM states (IDLE/BUS0/BUS1/RESP)
//   size_bytes  - access size to byte count (0 for ILLEGAL)
package mem_access_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    WORD    = 2'b01,
    DWORD   = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2,
    RESP = 2'd3
  } mem_state_e;

  function automatic logic [2:0] size_bytes(input mem_size_e s);
    case (s)
      BYTE:    size_bytes = 3'd1;
      WORD:    size_bytes = 3'd2;
      DWORD:   size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational lane steering for one access.
// Ports:
//   off        [1:0]  byte offset within the dword
//   size       [1:0]  mem_size_e encoding
//   half              0 = first bus cycle, 1 = second half of a split access
//   wdata      [31:0] right-justified store data
//   rdata      [31:0] read data of the current bus cycle
//   rdata_lo   [31:0] read data captured from the first half of a split load
//   byte_en    [3:0]  lane enables for the current bus cycle
//   wdata_lane [31:0] lane-positioned store data for the current bus cycle
//   load_data  [31:0] extracted/merged load result, zero-extended
//   split             access straddles a dword boundary
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        half,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] rdata_lo,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output logic        split
);

  logic [2:0]  nbytes;
  logic [3:0]  mask4;
  logic [7:0]  be_span;
  logic [63:0] w_span;
  logic [63:0] r_span;
  logic [63:0] r_shift;
  logic [31:0] dmask;

  assign nbytes = size_bytes(mem_size_e'(size));

  always_comb begin
    mask4 = 4'b0000;
    case (mem_size_e'(size))
      BYTE:    mask4 = 4'b0001;
      WORD:    mask4 = 4'b0011;
      DWORD:   mask4 = 4'b1111;
      default: mask4 = 4'b0000;
    endcase
  end

  // Positioning the access across an 8-lane (two dword) window gives both
  // halves at once: the low dword is the first bus cycle, the high dword is
  // the remainder that spills into the next dword.
  assign be_span = {4'b0000, mask4} << off;
  assign w_span  = {32'd0, wdata} << {off, 3'b000};

  assign byte_en    = half ? be_span[7:4] : be_span[3:0];
  assign wdata_lane = half ? w_span[63:32] : w_span[31:0];

  // Read merge: for the second half, the current read data forms the upper
  // dword of the window and the captured first-half data the lower.
  assign r_span  = half ? {rdata, rdata_lo} : {32'd0, rdata};
  assign r_shift = r_span >> {off, 3'b000};
  assign dmask   = {{8{mask4[3]}}, {8{mask4[2]}}, {8{mask4[1]}}, {8{mask4[0]}}};

  assign load_data = r_shift[31:0] & dmask;
  assign split     = ({1'b0, off} + nbytes) > 3'd4;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store memory stage. Converts one byte-addressed
// LOAD/STORE request at a time into aligned 32-bit bus cycles with byte
// enables, splits dword-crossing accesses into two bus cycles, aborts on a
// bus timeout and returns load data or a fault.
//
// Configuration macro: MEM_ACCESS_ALIGN_CHECK_EN
//   defined   - any dword-crossing access faults without a bus cycle; the
//               second-half bus cycle logic is compiled out.
//   undefined - dword-crossing accesses are split into two bus cycles.
//
// Parameters:
//   TIMEOUT_CYCLES  wait-state cycles tolerated per bus cycle (1..255)
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake
//   req_op, req_size, req_addr, req_wdata   request fields
//   mem_addr, mem_read, mem_write, mem_byte_en, mem_wdata   bus outputs
//   mem_rdata, mem_ready       bus read data and cycle completion
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_fault       response fields
//   state_dbg                  current FSM state (mem_state_e encoding)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Once valid is asserted its payload is held stable until the
// transfer. req_ready is high exactly in IDLE, rsp_valid exactly in RESP.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [1:0]  state_dbg
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  mem_state_e  state;
  mem_op_e     op_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic [7:0]  tmo_cnt;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_fault_q;

  logic        in_bus;
  logic        half;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_split;
  logic        tmo_hit;
  logic        req_bad;

  assign half = (state == BUS1);

  mem_lane_align u_align (
    .off        (off_q),
    .size       (size_q),
    .half       (half),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .rdata_lo   (lo_q),
    .byte_en    (al_be),
    .wdata_lane (al_wdata),
    .load_data  (al_load),
    .split      (al_split)
  );

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic req_misaligned;
  assign req_misaligned =
    ({1'b0, req_addr[1:0]} + size_bytes(mem_size_e'(req_size))) > 3'd4;
  assign req_bad = (mem_size_e'(req_size) == ILLEGAL) || req_misaligned;
`else
  assign req_bad = (mem_size_e'(req_size) == ILLEGAL);
`endif

  // Address, enables and data come straight from the captured request and
  // are only driven while a bus cycle is in progress, so they are stable
  // for the whole cycle and zero otherwise.
  assign in_bus      = (state == BUS0) || (state == BUS1);
  assign mem_addr    = !in_bus ? 32'd0 :
                       half    ? {addr_q + 30'd1, 2'b00} : {addr_q, 2'b00};
  assign mem_byte_en = in_bus ? al_be : 4'b0000;
  assign mem_wdata   = (in_bus && op_q == STORE) ? al_wdata : 32'd0;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign state_dbg = state;

  assign tmo_hit = (tmo_cnt + 8'd1) == TMO_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= LOAD;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      addr_q      <= 30'd0;
      wdata_q     <= 32'd0;
      lo_q        <= 32'd0;
      tmo_cnt     <= 8'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= mem_op_e'(req_op);
            size_q  <= req_size;
            off_q   <= req_addr[1:0];
            addr_q  <= req_addr[31:2];
            wdata_q <= req_wdata;
            tmo_cnt <= 8'd0;
            if (req_bad) begin
              state       <= RESP;
              rsp_rdata_q <= 32'd0;
              rsp_fault_q <= 1'b1;
            end else begin
              state <= BUS0;
              rd_q  <= (mem_op_e'(req_op) == LOAD);
              wr_q  <= (mem_op_e'(req_op) == STORE);
            end
          end
        end
        BUS0: begin
          if (mem_ready) begin
            tmo_cnt <= 8'd0;
`ifndef MEM_ACCESS_ALIGN_CHECK_EN
            if (al_split) begin
              state <= BUS1;
              lo_q  <= mem_rdata;
            end else
`endif
            begin
              state       <= RESP;
              rd_q        <= 1'b0;
              wr_q        <= 1'b0;
              rsp_rdata_q <= (op_q == LOAD) ? al_load : 32'd0;
              rsp_fault_q <= 1'b0;
            end
          end else if (tmo_hit) begin
            state       <= RESP;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_fault_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
`ifndef MEM_ACCESS_ALIGN_CHECK_EN
        BUS1: begin
          // A timeout here leaves the first half of a store already written.
          if (mem_ready || tmo_hit) begin
            state       <= RESP;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_rdata_q <= (mem_ready && op_q == LOAD) ? al_load : 32'd0;
            rsp_fault_q <= !mem_ready;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            state       <= IDLE;
            rsp_rdata_q <= 32'd0;
            rsp_fault_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_req(input logic op, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_op    = op;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write}); end
    checks++; if (mem_byte_en !== 4'b0000) begin errors++; $display("FAIL reset_byte_en: got %b expected 0000", mem_byte_en); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    checks++; if ({rsp_valid, rsp_fault} !== 2'b00 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp: got v=%b f=%b d=%h expected 0 0 0", rsp_valid, rsp_fault, rsp_rdata); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_load_dword();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ld_dword_ready: got %b expected 1", req_ready); end
    send_req(1'b0, 2'b10, 32'h0000_0100, 32'd0);
    // cycle 1: bus cycle
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL ld_dword_strobe: got r=%b w=%b expected 1 0", mem_read, mem_write); end
    checks++; if (mem_addr !== 32'h100 || mem_byte_en !== 4'b1111) begin errors++; $display("FAIL ld_dword_bus: got %h/%b expected 00000100/1111", mem_addr, mem_byte_en); end
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    // cycle 2: response
    checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0) begin errors++; $display("FAIL ld_dword_rsp: got v=%b f=%b expected 1 0", rsp_valid, rsp_fault); end
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_dword_data: got %h expected deadbeef", rsp_rdata); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL ld_dword_strobe_off: got %b expected 0", mem_read); end
    finish_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL ld_dword_idle: got rdy=%b v=%b expected 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_store_byte();
    send_req(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00AB);
    for (int i = 0; i < 2; i++) begin
      // first pass has a wait state; outputs must stay put across it
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL st_byte_strobe%0d: got r=%b w=%b expected 0 1", i, mem_read, mem_write); end
      checks++; if (mem_addr !== 32'h200 || mem_byte_en !== 4'b1000) begin errors++; $display("FAIL st_byte_bus%0d: got %h/%b expected 00000200/1000", i, mem_addr, mem_byte_en); end
      checks++; if (mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL st_byte_wdata%0d: got %h expected ab000000", i, mem_wdata); end
      mem_ready = (i == 1);
      tick();
    end
    mem_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL st_byte_rsp: got v=%b f=%b d=%h expected 1 0 0", rsp_valid, rsp_fault, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_split_load();
    send_req(1'b0, 2'b01, 32'h0000_1003, 32'd0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL split_ld_nostrobe: got r=%b w=%b expected 0 0", mem_read, mem_write); end
    checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL split_ld_fault: got v=%b f=%b d=%h expected 1 1 0", rsp_valid, rsp_fault, rsp_rdata); end
`else
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h1000 || mem_byte_en !== 4'b1000) begin errors++; $display("FAIL split_ld_bus0: got r=%b %h/%b expected 1 00001000/1000", mem_read, mem_addr, mem_byte_en); end
    mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
    tick();
    mem_rdata = 32'h5566_7788;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h1004 || mem_byte_en !== 4'b0001) begin errors++; $display("FAIL split_ld_bus1: got r=%b %h/%b expected 1 00001004/0001", mem_read, mem_addr, mem_byte_en); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL split_ld_early_rsp: got %b expected 0", rsp_valid); end
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'h0000_8811) begin errors++; $display("FAIL split_ld_rsp: got v=%b f=%b d=%h expected 1 0 00008811", rsp_valid, rsp_fault, rsp_rdata); end
`endif
    finish_rsp();
  endtask

  task automatic test_split_store();
    send_req(1'b1, 2'b01, 32'h0000_2003, 32'h0000_BBAA);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    checks++; if (mem_write !== 1'b0 || rsp_fault !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL split_st_fault: got w=%b v=%b f=%b expected 0 1 1", mem_write, rsp_valid, rsp_fault); end
`else
    checks++; if (mem_write !== 1'b1 || mem_byte_en !== 4'b1000 || mem_wdata !== 32'hAA00_0000) begin errors++; $display("FAIL split_st_bus0: got w=%b %b %h expected 1 1000 aa000000", mem_write, mem_byte_en, mem_wdata); end
    mem_ready = 1'b1;
    tick();
    checks++; if (mem_addr !== 32'h2004 || mem_byte_en !== 4'b0001 || mem_wdata !== 32'h0000_00BB) begin errors++; $display("FAIL split_st_bus1: got %h %b %h expected 00002004 0001 000000bb", mem_addr, mem_byte_en, mem_wdata); end
    tick();
    mem_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL split_st_rsp: got v=%b f=%b d=%h expected 1 0 0", rsp_valid, rsp_fault, rsp_rdata); end
`endif
    finish_rsp();
  endtask

  task automatic test_timeout();
    mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    send_req(1'b0, 2'b10, 32'h0000_0040, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_read !== 1'b1 || rsp_valid !== 1'b0 || mem_addr !== 32'h40) begin errors++; $display("FAIL tmo_wait%0d: got r=%b v=%b a=%h expected 1 0 00000040", i, mem_read, rsp_valid, mem_addr); end
      tick();
    end
    mem_rdata = 32'h0;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL tmo_strobe_drop: got %b expected 0", mem_read); end
    checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL tmo_rsp: got v=%b f=%b d=%h expected 1 1 0", rsp_valid, rsp_fault, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_illegal_size();
    send_req(1'b0, 2'b11, 32'h0000_0010, 32'd0);
    // cycle 1: response already valid, no bus cycle
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL illegal_nostrobe: got r=%b w=%b expected 0 0", mem_read, mem_write); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_rdata !== 32'd0 || req_ready !== 1'b0) begin errors++; $display("FAIL illegal_hold%0d: got v=%b f=%b d=%h rdy=%b expected 1 1 0 0", i, rsp_valid, rsp_fault, rsp_rdata, req_ready); end
      tick();
    end
    finish_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL illegal_release: got rdy=%b v=%b expected 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_reset_mid_access();
    mem_ready = 1'b0;
    send_req(1'b0, 2'b10, 32'h0000_0080, 32'd0);
    tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", mem_read); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || rsp_valid !== 1'b0 || mem_byte_en !== 4'b0000) begin errors++; $display("FAIL rst_mid_async: got r=%b v=%b be=%b expected 0 0 0000", mem_read, rsp_valid, mem_byte_en); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_noresp: got v=%b rdy=%b expected 0 1", rsp_valid, req_ready); end
    send_req(1'b0, 2'b00, 32'h0000_0081, 32'd0);
    checks++; if (mem_read !== 1'b1 || mem_byte_en !== 4'b0010 || mem_addr !== 32'h80) begin errors++; $display("FAIL rst_mid_next_bus: got r=%b %b %h expected 1 0010 00000080", mem_read, mem_byte_en, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h1234_CC56;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'h0000_00CC) begin errors++; $display("FAIL rst_mid_next_rsp: got v=%b f=%b d=%h expected 1 0 000000cc", rsp_valid, rsp_fault, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    // word load at offset 2 fits in one dword; issue right after the previous handshake
    send_req(1'b0, 2'b01, 32'h0000_0302, 32'd0);
    checks++; if (mem_read !== 1'b1 || mem_byte_en !== 4'b1100) begin errors++; $display("FAIL b2b_bus: got r=%b be=%b expected 1 1100", mem_read, mem_byte_en); end
    mem_ready = 1'b1; mem_rdata = 32'hA1B2_C3D4;
    tick();
    mem_ready = 1'b0;
    checks++; if (rsp_rdata !== 32'h0000_A1B2) begin errors++; $display("FAIL b2b_data: got %h expected 0000a1b2", rsp_rdata); end
    // mem_ready in RESP must be ignored
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_A1B2 || mem_read !== 1'b0) begin errors++; $display("FAIL b2b_hold: got v=%b d=%h r=%b expected 1 0000a1b2 0", rsp_valid, rsp_rdata, mem_read); end
    finish_rsp();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_size = 2'b00;
    req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    rsp_ready = 1'b0;
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_load_dword();
    test_store_byte();
    test_split_load();
    test_split_store();
    test_timeout();
    test_illegal_size();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store memory stage that sits directly downstream of the execute stage. It accepts one LOAD or STORE request at a time over a valid/ready handshake and converts the byte address and size into aligned 32-bit bus cycles with byte enables. It tolerates memory wait states, aborts on a bus timeout, and returns load data or a fault to the writeback path over a second valid/ready handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: wait-state cycles tolerated per bus cycle before abort; legal range 1..255.

Ports:
- `clk` input 1: sole clock; every register samples on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_op` input 1: 0 = LOAD, 1 = STORE.
- `req_size` input 2: 00 = byte, 01 = word, 10 = dword, 11 = illegal.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `mem_addr` output 32: dword-aligned bus address.
- `mem_read` output 1: read strobe.
- `mem_write` output 1: write strobe.
- `mem_byte_en` output 4: lane enables.
- `mem_wdata` output 32: lane-positioned write data.
- `mem_rdata` input 32: read data, valid when `mem_ready` is high.
- `mem_ready` input 1: completes the current bus cycle.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_rdata` output 32: load data, zero-extended; 0 for stores and faults.
- `rsp_fault` output 1: access failed.

## Operation
- Request fields are captured on `req_valid && req_ready`. `req_ready` = (state == IDLE).
- FSM states and transitions:
  - IDLE → BUS0 on accept.
  - IDLE → RESP with fault when `req_size` is 11. No bus cycle is issued.
  - BUS0 → BUS1 when the access is split and `mem_ready` is high.
  - BUS0 → RESP when the access is not split and `mem_ready` is high.
  - BUS1 → RESP when `mem_ready` is high.
  - RESP → IDLE when `rsp_ready` is high.
- In BUS0 and BUS1, `mem_read` or `mem_write` is held high for the whole cycle. Address, enables and data are stable until `mem_ready`.
- Lane rules, with `off = addr[1:0]` and `n` = 1/2/4 bytes:
  - `mem_addr` = {addr[31:2], 2'b00}.
  - `mem_byte_en` = ((1<<n)-1) << off, truncated to 4 bits.
  - `mem_wdata` = `req_wdata` << (8*off).
- Split access: an access is split when off + n > 4.
  - BUS1 uses `mem_addr` + 4, enables for the remaining bytes starting at lane 0, and write data = `req_wdata` >> (8*(4-off)).
  - Load result = (hi_lanes << 8*(4-off)) | (lo_rdata >> 8*off), masked to `n` bytes.
- Timeout: the counter clears on entry to each BUS state and increments on every BUS cycle with `mem_ready` low. When it reaches `TIMEOUT_CYCLES`, the strobe drops and the FSM goes to RESP with fault.
- A split STORE that times out in BUS1 leaves the first half written. Stores are non-atomic by design.
- `rsp_valid` = (state == RESP). Response data and fault are held stable until the response is accepted.

## Timing
- Reset values: `req_ready` = 1 (IDLE), strobes 0, `mem_byte_en` 0, `mem_addr` 0, `mem_wdata` 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_fault` 0.
- Minimum latency for an unsplit access: accept at cycle 0, bus cycle at cycle 1 with `mem_ready`, `rsp_valid` at cycle 2.
- A split access adds one cycle plus any wait states.
- Illegal size: `rsp_valid` asserts at cycle 1.
- The next request can be accepted in the cycle after the response handshake. There is no overlap; throughput is at most one access per 3 cycles.
- Reset asserted mid-access drops the strobes and `rsp_valid` asynchronously. The in-flight request is discarded with no response.
- `mem_ready` outside BUS0/BUS1 is ignored.

## Configuration
- `MEM_ACCESS_ALIGN_CHECK_EN` defined: any access with off + n > 4 goes IDLE → RESP with fault and no bus cycle. BUS1 logic is compiled out.
- Not defined: misaligned accesses are split into two bus cycles as described in Operation.

## Structure
- `mem_access_pkg` holds:
  - `mem_op_e` (LOAD/STORE) and `mem_size_e` (BYTE/WORD/DWORD/ILLEGAL).
  - `mem_state_e` (IDLE/BUS0/BUS1/RESP).
  - The size-to-byte-count function.
- Sub-module `mem_lane_align` is purely combinational. It takes the offset, size and which half of a split access is in progress, and produces the byte enables, positioned write data and the extract/merge of read data.

## Test plan
- LOAD dword at 0x100 with memory returning 0xDEADBEEF and zero wait states → `mem_byte_en` = 1111, `rsp_rdata` = 0xDEADBEEF, `rsp_valid` at cycle 2.
- STORE byte 0xAB to 0x203 → `mem_addr` = 0x200, `mem_byte_en` = 1000, `mem_wdata` = 0xAB000000, `rsp_fault` = 0.
- LOAD word at 0x1003 with no macro; dword 0x1000 holds 0x11223344 and dword 0x1004 holds 0x55667788 → two bus cycles with enables 1000 then 0001, `rsp_rdata` = 0x00008811. With the macro defined → `rsp_fault` = 1 and no strobe.
- LOAD at 0x40 with `mem_ready` held low and `TIMEOUT_CYCLES` = 4 → strobe high for 4 cycles, then `rsp_fault` = 1 and `rsp_rdata` = 0.
- `req_size` = 11 → no strobe, `rsp_fault` = 1 at cycle 1. Hold `rsp_ready` low for 3 cycles → response stable and `req_ready` = 0 throughout.
- Assert `rst_n` low during BUS0 with a 2-cycle wait state → `mem_read` drops immediately, no response; after release the next request completes normally.
